csa_stream_accumulator: RTL and testbench

- Sequential, parametrised multi-operand adder.
- Accepts WIDTH-bit operands one per cycle over a valid/ready stream.
- Holds the running total in carry-save form (sum vector S, carry vector C) using one 3:2 compressor row per accepted operand.
- After N_OPS operands, resolves S+C in one carry-propagate cycle and presents the total on a valid/ready output port.
- Replaces fixed-count combinational CSA trees in datapaths where operands arrive serially.

---
 rtl/csa_stream_accumulator.sv | 146 ++++++++++++++
 tb/tb_csa_stream_accumulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Serial multi-operand adder. Operands arrive one per cycle on a valid/ready
// stream. The running total is kept in carry-save form (S, C), so each accepted
// operand costs only one 3:2 compressor row. After N_OPS operands a single
// carry-propagate add resolves S+C, and the total is offered on a valid/ready
// output port.
module csa_stream_accumulator #(
  parameter int WIDTH  = 16,
  parameter int N_OPS  = 9,
  parameter int SIGNED = 0,
  parameter int ACC_W  = WIDTH + $clog2(N_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [ACC_W-1:0] out_full,
  output logic             out_ovf,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(N_OPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] s_vec;
  logic [ACC_W-1:0] c_vec;
  logic [CNT_W-1:0] count;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] s_csa;
  logic [ACC_W-1:0] c_csa;
  logic [ACC_W-1:0] resolved;
  logic             accept;

  // Widen an operand to the accumulator width; the sign bit is replicated
  // only when operands are two's complement.
  function automatic logic [ACC_W-1:0] extend(input logic [WIDTH-1:0] d);
    logic sign_bit;
    sign_bit = (SIGNED != 0) ? d[WIDTH-1] : 1'b0;
    return {{(ACC_W - WIDTH){sign_bit}}, d};
  endfunction

  // Does the full-precision total fit in WIDTH bits? Unsigned: upper bits must
  // be zero. Signed: upper bits plus the WIDTH sign bit must all agree.
  function automatic logic range_ovf(input logic [ACC_W-1:0] f);
    logic [ACC_W-WIDTH:0] top;
    top = f[ACC_W-1:WIDTH-1];
    if (SIGNED != 0) return !((&top) || !(|top));
    else             return |top[ACC_W-WIDTH:1];
  endfunction

  // Operand extension, one 3:2 compressor row, and the final resolve adder.
  always_comb begin
    x_ext    = extend(in_data);
    s_csa    = s_vec ^ c_vec ^ x_ext;
    c_csa    = ((s_vec & c_vec) | (s_vec & x_ext) | (c_vec & x_ext)) << 1;
    resolved = s_vec + c_vec;
  end

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake/status outputs, all decoded from the state.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (count == LAST_CNT)) state_next = RESOLVE;
      end
      RESOLVE: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry-save accumulation, operand count and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_vec    <= '0;
      c_vec    <= '0;
      count    <= '0;
      out_full <= '0;
      out_sum  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_vec <= x_ext;
            c_vec <= '0;
            count <= CNT_W'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            s_vec <= s_csa;
            c_vec <= c_csa;
            count <= count + CNT_W'(1);
          end
        end
        RESOLVE: begin
          out_full <= resolved;
          out_sum  <= resolved[WIDTH-1:0];
          out_ovf  <= range_ovf(resolved);
        end
        DONE: begin
          if (out_ready) begin
            s_vec <= '0;
            c_vec <= '0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator: one unsigned and one signed
// instance (WIDTH=16, N_OPS=9) driven with hand-computed vectors.
module tb_csa_stream_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_ovf, u_busy;
  logic [15:0] u_in_data, u_out_sum;
  logic [19:0] u_out_full;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf, s_busy;
  logic [15:0] s_in_data, s_out_sum;
  logic [19:0] s_out_full;

  int n_cmp = 0;
  int n_err = 0;

  csa_stream_accumulator #(.WIDTH(16), .N_OPS(9), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_data(u_in_data), .out_valid(u_out_valid), .out_ready(u_out_ready),
    .out_sum(u_out_sum), .out_full(u_out_full), .out_ovf(u_out_ovf), .busy(u_busy)
  );

  csa_stream_accumulator #(.WIDTH(16), .N_OPS(9), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_full(s_out_full), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic u_push(input logic [15:0] d);
    u_in_valid = 1'b1; u_in_data = d;
    tick();
  endtask

  task automatic s_push(input logic [15:0] d);
    s_in_valid = 1'b1; s_in_data = d;
    tick();
  endtask

  task automatic u_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (u_out_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic s_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (s_out_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%0h exp=0", u_out_valid); end
    n_cmp++; if (u_out_sum !== 16'h0) begin n_err++; $display("FAIL rst_out_sum got=%0h exp=0", u_out_sum); end
    n_cmp++; if (u_out_full !== 20'h0) begin n_err++; $display("FAIL rst_out_full got=%0h exp=0", u_out_full); end
    n_cmp++; if (u_out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_out_ovf got=%0h exp=0", u_out_ovf); end
    n_cmp++; if (u_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%0h exp=1", u_in_ready); end
    n_cmp++; if (u_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", u_busy); end
    n_cmp++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_signed_hs got rdy=%0h vld=%0h exp rdy=1 vld=0", s_in_ready, s_out_valid); end
    tick();
    n_cmp++; if (u_in_ready !== 1'b1 || u_busy !== 1'b0) begin n_err++; $display("FAIL rst_release got rdy=%0h busy=%0h exp rdy=1 busy=0", u_in_ready, u_busy); end
  endtask

  task automatic test_basic();
    u_out_ready = 1'b1;
    u_push(16'd0);
    n_cmp++; if (u_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_accum got=%0h exp=1", u_busy); end
    for (int i = 1; i < 8; i++) u_push(16'(i));
    u_push(16'd100);
    u_in_valid = 1'b0;
    n_cmp++; if (u_out_valid !== 1'b0 || u_in_ready !== 1'b0 || u_busy !== 1'b1) begin n_err++; $display("FAIL basic_resolve got vld=%0h rdy=%0h busy=%0h exp 0/0/1", u_out_valid, u_in_ready, u_busy); end
    tick();
    n_cmp++; if (u_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_out_valid got=%0h exp=1", u_out_valid); end
    n_cmp++; if (u_out_sum !== 16'd128) begin n_err++; $display("FAIL basic_out_sum got=%0d exp=128", u_out_sum); end
    n_cmp++; if (u_out_full !== 20'd128) begin n_err++; $display("FAIL basic_out_full got=%0d exp=128", u_out_full); end
    n_cmp++; if (u_out_ovf !== 1'b0) begin n_err++; $display("FAIL basic_out_ovf got=%0h exp=0", u_out_ovf); end
    n_cmp++; if (u_busy !== 1'b0 || u_in_ready !== 1'b0) begin n_err++; $display("FAIL basic_done_status got busy=%0h rdy=%0h exp 0/0", u_busy, u_in_ready); end
    tick();
    n_cmp++; if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_drain got vld=%0h rdy=%0h exp 0/1", u_out_valid, u_in_ready); end
    n_cmp++; if (u_out_sum !== 16'd128) begin n_err++; $display("FAIL basic_sum_hold got=%0d exp=128", u_out_sum); end
  endtask

  task automatic test_unsigned_ovf();
    bit ok;
    u_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) u_push(16'hFFFF);
    u_in_valid = 1'b0;
    u_wait(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL uovf_timeout got=no_valid exp=valid"); end
    n_cmp++; if (u_out_full !== 20'h8FFF7) begin n_err++; $display("FAIL uovf_full got=%0h exp=8fff7", u_out_full); end
    n_cmp++; if (u_out_sum !== 16'hFFF7) begin n_err++; $display("FAIL uovf_sum got=%0h exp=fff7", u_out_sum); end
    n_cmp++; if (u_out_ovf !== 1'b1) begin n_err++; $display("FAIL uovf_flag got=%0h exp=1", u_out_ovf); end
    tick();
  endtask

  task automatic test_stalls();
    bit ok;
    u_out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      u_push(16'(i));
      u_in_valid = 1'b0;
      if (i < 9) begin
        tick(); tick();
        n_cmp++; if (u_busy !== 1'b1 || u_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_gap%0d got busy=%0h rdy=%0h exp 1/1", i, u_busy, u_in_ready); end
      end
    end
    u_wait(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout got=no_valid exp=valid"); end
    u_in_valid = 1'b1; u_in_data = 16'd7;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (u_in_ready !== 1'b0 || u_out_valid !== 1'b1 || u_out_sum !== 16'd45 || u_out_full !== 20'd45) begin
        n_err++; $display("FAIL stall_hold%0d got rdy=%0h vld=%0h sum=%0d full=%0d exp 0/1/45/45", i, u_in_ready, u_out_valid, u_out_sum, u_out_full);
      end
      tick();
    end
    u_in_valid = 1'b0;
    u_out_ready = 1'b1;
    tick();
    u_out_ready = 1'b0;
    n_cmp++; if (u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got rdy=%0h vld=%0h exp 1/0", u_in_ready, u_out_valid); end
    u_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) u_push(16'd1);
    u_in_valid = 1'b0;
    u_wait(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall2_timeout got=no_valid exp=valid"); end
    n_cmp++; if (u_out_sum !== 16'd9 || u_out_full !== 20'd9) begin n_err++; $display("FAIL stall2_sum got sum=%0d full=%0d exp 9/9", u_out_sum, u_out_full); end
    tick();
  endtask

  task automatic test_signed();
    bit ok;
    s_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) s_push(16'hFFFF);
    s_push(16'h0005);
    s_in_valid = 1'b0;
    s_wait(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sgn1_timeout got=no_valid exp=valid"); end
    n_cmp++; if (s_out_sum !== 16'hFFFD) begin n_err++; $display("FAIL sgn1_sum got=%0h exp=fffd", s_out_sum); end
    n_cmp++; if (s_out_full !== 20'hFFFFD) begin n_err++; $display("FAIL sgn1_full got=%0h exp=ffffd", s_out_full); end
    n_cmp++; if (s_out_ovf !== 1'b0) begin n_err++; $display("FAIL sgn1_ovf got=%0h exp=0", s_out_ovf); end
    tick();
    for (int i = 0; i < 9; i++) s_push(16'h8000);
    s_in_valid = 1'b0;
    s_wait(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL sgn2_timeout got=no_valid exp=valid"); end
    n_cmp++; if (s_out_full !== 20'hB8000) begin n_err++; $display("FAIL sgn2_full got=%0h exp=b8000", s_out_full); end
    n_cmp++; if (s_out_sum !== 16'h8000) begin n_err++; $display("FAIL sgn2_sum got=%0h exp=8000", s_out_sum); end
    n_cmp++; if (s_out_ovf !== 1'b1) begin n_err++; $display("FAIL sgn2_ovf got=%0h exp=1", s_out_ovf); end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    u_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) u_push(16'd1000);
    u_in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (u_busy !== 1'b0 || u_in_ready !== 1'b1 || u_out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_status got busy=%0h rdy=%0h vld=%0h exp 0/1/0", u_busy, u_in_ready, u_out_valid); end
    for (int i = 0; i < 8; i++) u_push(16'(i));
    u_push(16'd100);
    u_in_valid = 1'b0;
    u_wait(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mrst_timeout got=no_valid exp=valid"); end
    n_cmp++; if (u_out_sum !== 16'd128 || u_out_full !== 20'd128) begin n_err++; $display("FAIL mrst_sum got sum=%0d full=%0d exp 128/128", u_out_sum, u_out_full); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_unsigned_ovf();
    test_stalls();
    test_signed();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
